// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer for the 3x3 Sobel gradient datapath.
// Optional macro SOBEL_THRESH_EN adds a thresh port that turns out_data into a binary edge map.
module sobel_frame_ctrl #(
  parameter int H_BITS = 11,
  parameter int V_BITS = 11,
  parameter int D_W    = 11,
  parameter int LAT    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [H_BITS-1:0] cfg_width,
  input  logic [V_BITS-1:0] cfg_height,
  input  logic              pix_valid,
`ifdef SOBEL_THRESH_EN
  input  logic [D_W-1:0]    thresh,
`endif
  output logic              sobel_en,
  input  logic [D_W-1:0]    sobel_data,
  output logic              out_valid,
  output logic [D_W-1:0]    out_data,
  output logic [H_BITS-1:0] out_x,
  output logic [V_BITS-1:0] out_y,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
);
  localparam int TW = 1 + H_BITS + V_BITS;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [H_BITS-1:0] col_q, col_d, w_q, w_d, tx_q, tx_d, ox_q, ox_d;
  logic [V_BITS-1:0] row_q, row_d, h_q, h_d, ty_q, ty_d, oy_q, oy_d;
  logic [D_W-1:0] od_q, od_d, res;
  logic en_q, en_d, ov_q, ov_d, err_q, err_d;
  logic [TW-1:0] dl_q [LAT];
  logic [TW-1:0] dl_d [LAT];
  logic [TW-1:0] tap;
  logic cfg_ok, accept, inflight;
  assign tap    = dl_q[LAT-1];
  assign cfg_ok = (cfg_width >= H_BITS'(3)) && (cfg_height >= V_BITS'(3));
  assign accept = (state_q == RUN) && pix_valid && !frame_start;
`ifdef SOBEL_THRESH_EN
  logic [D_W-1:0] thr_q, thr_d;
  assign thr_d = frame_start ? thresh : thr_q;
  assign res   = (sobel_data >= thr_q) ? '1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) thr_q <= '0;
    else        thr_q <= thr_d;
`else
  assign res = sobel_data;
`endif
  // the enable register counts as in flight: its token has not yet entered the delay line
  always_comb begin
    inflight = en_q | ov_q;
    for (int i = 0; i < LAT; i++) inflight = inflight | dl_q[i][TW-1];
  end
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    err_d   = err_q;
    en_d    = 1'b0;
    tx_d    = tx_q;
    ty_d    = ty_q;
    dl_d[0] = {en_q, tx_q, ty_q};
    for (int i = 1; i < LAT; i++) dl_d[i] = dl_q[i-1];
    ov_d = tap[TW-1];
    ox_d = tap[TW-1] ? tap[TW-2 -: H_BITS] : ox_q;
    oy_d = tap[TW-1] ? tap[V_BITS-1:0] : oy_q;
    od_d = tap[TW-1] ? res : od_q;
    if (accept) begin
      en_d  = (col_q >= H_BITS'(2)) && (row_q >= V_BITS'(2));
      tx_d  = col_q - H_BITS'(1);
      ty_d  = row_q - V_BITS'(1);
      col_d = (col_q == w_q - H_BITS'(1)) ? '0 : col_q + H_BITS'(1);
      if (col_q == w_q - H_BITS'(1)) begin
        row_d = row_q + V_BITS'(1);
        if (row_q == h_q - V_BITS'(1)) state_d = DRAIN;
      end
    end
    if (state_q == DRAIN && !inflight) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
    // a new frame flushes every token of the old one before it can reach the output
    if (frame_start) begin
      state_d = cfg_ok ? RUN : DONE;
      col_d   = '0;
      row_d   = '0;
      w_d     = cfg_width;
      h_d     = cfg_height;
      err_d   = !cfg_ok;
      ov_d    = 1'b0;
      for (int i = 0; i < LAT; i++) dl_d[i][TW-1] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      tx_q    <= '0;
      ty_q    <= '0;
      dl_q    <= '{default: '0};
      ov_q    <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
      err_q   <= err_d;
      en_q    <= en_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      dl_q    <= dl_d;
      ov_q    <= ov_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      od_q    <= od_d;
    end
  end
  assign sobel_en   = en_q;
  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign out_x      = ox_q;
  assign out_y      = oy_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);
  assign cfg_err    = err_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed frames against a cycle-indexed expectation model of sobel_frame_ctrl.
module tb_sobel_frame_ctrl;
  localparam int HB = 11, VB = 11, DW = 11, LAT = 5, N = 1024;
  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, pix_valid = 1'b0;
  logic [HB-1:0] cfg_width = '0;
  logic [VB-1:0] cfg_height = '0;
  logic [DW-1:0] sobel_data = '0;
`ifdef SOBEL_THRESH_EN
  logic [DW-1:0] thresh = 11'd100;
`endif
  logic sobel_en, out_valid, busy, frame_done, cfg_err;
  logic [DW-1:0] out_data;
  logic [HB-1:0] out_x;
  logic [VB-1:0] out_y;

  sobel_frame_ctrl #(.H_BITS(HB), .V_BITS(VB), .D_W(DW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .pix_valid(pix_valid),
`ifdef SOBEL_THRESH_EN
    .thresh(thresh),
`endif
    .sobel_en(sobel_en), .sobel_data(sobel_data), .out_valid(out_valid),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0, n_ov = 0, n_done = 0;
  bit e_en[N], e_ov[N], e_busy[N], e_done[N], e_err[N];
  int e_x[N], e_y[N], e_d[N];
  bit m_run = 1'b0;
  int m_col = 0, m_row = 0, m_w = 0, m_h = 0;
  int vals[8] = '{99, 100, 2047, 0, 1234, 101, 7, 512};

  function automatic int dv(int c);
    return vals[c % 8];
  endfunction

  function automatic int xf(int v);
`ifdef SOBEL_THRESH_EN
    return (v >= 100) ? 2047 : 0;
`else
    return v;
`endif
  endfunction

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < N) begin
      check("sobel_en", int'(sobel_en), int'(e_en[cyc]));
      check("out_valid", int'(out_valid), int'(e_ov[cyc]));
      check("busy", int'(busy), int'(e_busy[cyc]));
      check("frame_done", int'(frame_done), int'(e_done[cyc]));
      check("cfg_err", int'(cfg_err), int'(e_err[cyc]));
      if (e_ov[cyc]) begin
        check("out_x", int'(out_x), e_x[cyc]);
        check("out_y", int'(out_y), e_y[cyc]);
        check("out_data", int'(out_data), e_d[cyc]);
      end
    end
    if (out_valid) n_ov++;
    if (frame_done) n_done++;
  end

  task automatic step(bit fs, int w, int h, bit pv);
    int c = cyc;
    if (c > N - 20) begin
      $display("FAIL cycle_budget got=%0d want<%0d", c, N - 20);
      $fatal(1, "cycle budget exhausted");
    end
    frame_start = fs;
    cfg_width   = HB'(w);
    cfg_height  = VB'(h);
    pix_valid   = pv;
    sobel_data  = DW'(dv(c));
    if (fs) begin
      bit ok = (w >= 3) && (h >= 3);
      for (int k = c + 1; k < N; k++) begin
        e_ov[k] = 0; e_done[k] = 0; e_en[k] = 0; e_busy[k] = ok; e_err[k] = !ok;
      end
      if (!ok) e_done[c+1] = 1;
      m_run = ok; m_col = 0; m_row = 0; m_w = w; m_h = h;
    end else if (pv && m_run) begin
      if (m_col >= 2 && m_row >= 2) begin
        e_en[c+1] = 1;
        e_ov[c+LAT+2] = 1;
        e_x[c+LAT+2] = m_col - 1;
        e_y[c+LAT+2] = m_row - 1;
        e_d[c+LAT+2] = xf(dv(c + LAT + 1));
      end
      if (m_col == m_w - 1) begin
        m_col = 0;
        if (m_row == m_h - 1) begin
          m_run = 0;
          e_done[c+LAT+4] = 1;
          for (int k = c + LAT + 4; k < N; k++) e_busy[k] = 0;
        end else m_row++;
      end else m_col++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    int c = cyc;
    for (int k = c; k < N; k++) begin
      e_en[k] = 0; e_ov[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0;
    end
    m_run = 0;
    frame_start = 0;
    pix_valid = 0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sobel_en", int'(sobel_en), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t0, ov0, nd0;
    int en_off[4] = '{11, 12, 15, 16};
    int ov_off[4] = '{17, 18, 21, 22};
    int xs[4] = '{1, 2, 1, 2};
    int ys[4] = '{1, 1, 2, 2};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // 4x4 frame, back-to-back pixels; pin the model with hand-derived timing
    step(1, 4, 4, 0);
    t0 = cyc;
    for (int i = 0; i < 16; i++) step(0, 4, 4, 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_en_model", int'(e_en[t0+en_off[i]]), 1);
      check("t1_ov_model", int'(e_ov[t0+ov_off[i]]), 1);
      check("t1_x_model", e_x[t0+ov_off[i]], xs[i]);
      check("t1_y_model", e_y[t0+ov_off[i]], ys[i]);
    end
    check("t1_en_gap_model", int'(e_en[t0+13]), 0);
    check("t1_done_model", int'(e_done[t0+24]), 1);
    check("t1_busy23_model", int'(e_busy[t0+23]), 1);
    check("t1_busy24_model", int'(e_busy[t0+24]), 0);
    idle(LAT + 8);
    // same frame, pixels every other cycle
    ov0 = n_ov;
    step(1, 4, 4, 0);
    for (int i = 0; i < 32; i++) step(0, 4, 4, (i % 2) == 0);
    idle(LAT + 8);
    check("t2_out_count", n_ov - ov0, 4);
    // rejected config, then a valid frame clears cfg_err
    step(1, 2, 8, 0);
    check("t3_done", int'(frame_done), 1);
    check("t3_err", int'(cfg_err), 1);
    idle(4);
    // abort after 30 pixels, then a full 8x8 frame
    step(1, 8, 8, 0);
    for (int i = 0; i < 30; i++) step(0, 8, 8, 1);
    step(1, 8, 8, 0);
    ov0 = n_ov;
    nd0 = n_done;
    check("t4_err_cleared", int'(cfg_err), 0);
    for (int i = 0; i < 64; i++) step(0, 8, 8, 1);
    idle(LAT + 8);
    check("t4_out_count", n_ov - ov0, 36);
    check("t4_done_count", n_done - nd0, 1);
    // reset while draining with tokens in flight
    step(1, 5, 4, 0);
    for (int i = 0; i < 20; i++) step(0, 5, 4, 1);
    idle(2);
    rst_pulse();
    ov0 = n_ov;
    nd0 = n_done;
    idle(20);
    check("t6_no_out", n_ov - ov0, 0);
    check("t6_no_done", n_done - nd0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
